// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV64 pipeline.
// Holds the byte-addressed little-endian data memory and resolves branches.
// Also holds the MEM/WB pipeline register.
// All state uses a synchronous, active-high reset and updates on the rising edge of clk.
module mem_stage #(
  parameter int MEM_BYTES = 512,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [4:0]  EX_MEM_rd,
  input  logic [63:0] EX_MEM_mux_ALU,
  input  logic [63:0] EX_MEM_mux_ForwardB,
  input  logic        EX_MEM_ALUzero,
  input  logic [63:0] EX_MEM_adder2out,
  input  logic        EX_MEM_Branch,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_MemtoReg,
  input  logic [2:0]  EX_MEM_funct3,
  output logic        PCSrc,
  output logic [63:0] branch_target,
  output logic [4:0]  MEM_WB_rd,
  output logic [63:0] MEM_WB_ReadData,
  output logic [63:0] MEM_WB_ALUresult,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg,
  output logic        mem_fault
);

  // Lane (0..7) within the 64-bit store word that feeds a byte at a given offset from addr.
  function automatic logic [2:0] byte_lane(input logic [AW-1:0] off);
    return off[2:0];
  endfunction

  logic [7:0]    mem_q [MEM_BYTES];
  logic [7:0]    mem_d [MEM_BYTES];

  logic [4:0]    rd_q, rd_d;
  logic [63:0]   read_data_q, read_data_d;
  logic [63:0]   alu_result_q, alu_result_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic          fault_q, fault_d;

  logic [AW-1:0] addr;
  logic [AW-1:0] width;
  logic          misaligned;
  logic          reserved;
  logic          fault;
  logic          store_en;
  logic [7:0]    rd_bytes [8];
  logic [7:0]    st_bytes [8];
  logic [63:0]   load_raw;
  logic [63:0]   load_data;
  logic          unused_addr_hi;

  // Upper address bits fold away: the memory wraps modulo MEM_BYTES.
  assign addr           = EX_MEM_mux_ALU[AW-1:0];
  assign unused_addr_hi = ^EX_MEM_mux_ALU[63:AW];

  // Branch resolution is purely combinational; stall and reset do not affect it.
  assign PCSrc         = EX_MEM_Branch & EX_MEM_ALUzero;
  assign branch_target = EX_MEM_adder2out;

  // Decode access width, alignment, reserved encodings and the resulting fault.
  always_comb begin
    width      = AW'(4'd1);
    misaligned = 1'b0;
    case (EX_MEM_funct3[1:0])
      2'b00:   begin width = AW'(4'd1); misaligned = 1'b0;            end
      2'b01:   begin width = AW'(4'd2); misaligned = addr[0];         end
      2'b10:   begin width = AW'(4'd4); misaligned = |addr[1:0];      end
      2'b11:   begin width = AW'(4'd8); misaligned = |addr[2:0];      end
      default: begin width = AW'(4'd1); misaligned = 1'b1;            end
    endcase
    reserved = (EX_MEM_MemRead  & (EX_MEM_funct3 == 3'b111)) |
               (EX_MEM_MemWrite & EX_MEM_funct3[2]);
    fault    = (EX_MEM_MemRead | EX_MEM_MemWrite) &
               (misaligned | reserved | (EX_MEM_MemRead & EX_MEM_MemWrite));
    store_en = EX_MEM_MemWrite & ~fault & ~stall & ~reset;
  end

  // Gather the eight bytes starting at addr (with wrap) and split the store word into bytes.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rd_bytes[i] = mem_q[addr + AW'(i)];
      st_bytes[i] = EX_MEM_mux_ForwardB[8*i +: 8];
    end
    load_raw = {rd_bytes[7], rd_bytes[6], rd_bytes[5], rd_bytes[4],
                rd_bytes[3], rd_bytes[2], rd_bytes[1], rd_bytes[0]};
  end

  // Size and sign handling of the loaded value; non-loads and faults read as zero.
  always_comb begin
    case (EX_MEM_funct3)
      3'b000:  load_data = {{56{load_raw[7]}},  load_raw[7:0]};
      3'b001:  load_data = {{48{load_raw[15]}}, load_raw[15:0]};
      3'b010:  load_data = {{32{load_raw[31]}}, load_raw[31:0]};
      3'b011:  load_data = load_raw;
      3'b100:  load_data = {56'd0, load_raw[7:0]};
      3'b101:  load_data = {48'd0, load_raw[15:0]};
      3'b110:  load_data = {32'd0, load_raw[31:0]};
      default: load_data = 64'd0;
    endcase
    if (!EX_MEM_MemRead || fault) begin
      load_data = 64'd0;
    end else begin
      load_data = load_data;
    end
  end

  // Next memory contents: clear on reset, otherwise merge store bytes into the addressed window.
  always_comb begin
    for (int b = 0; b < MEM_BYTES; b++) begin
      if (reset) begin
        mem_d[b] = 8'd0;
      end else if (store_en && ((AW'(b) - addr) < width)) begin
        mem_d[b] = st_bytes[byte_lane(AW'(b) - addr)];
      end else begin
        mem_d[b] = mem_q[b];
      end
    end
  end

  // Next MEM/WB register state: reset clears, stall holds (fault drops), otherwise capture.
  always_comb begin
    rd_d         = rd_q;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    fault_d      = fault_q;
    if (reset) begin
      rd_d         = 5'd0;
      read_data_d  = 64'd0;
      alu_result_d = 64'd0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      fault_d      = 1'b0;
    end else if (stall) begin
      fault_d      = 1'b0;
    end else begin
      rd_d         = EX_MEM_rd;
      read_data_d  = load_data;
      alu_result_d = EX_MEM_mux_ALU;
      reg_write_d  = EX_MEM_RegWrite & ~fault;
      mem_to_reg_d = EX_MEM_MemtoReg;
      fault_d      = fault;
    end
  end

  // State registers: data memory and MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    mem_q        <= mem_d;
    rd_q         <= rd_d;
    read_data_q  <= read_data_d;
    alu_result_q <= alu_result_d;
    reg_write_q  <= reg_write_d;
    mem_to_reg_q <= mem_to_reg_d;
    fault_q      <= fault_d;
  end

  assign MEM_WB_rd        = rd_q;
  assign MEM_WB_ReadData  = read_data_q;
  assign MEM_WB_ALUresult = alu_result_q;
  assign MEM_WB_RegWrite  = reg_write_q;
  assign MEM_WB_MemtoReg  = mem_to_reg_q;
  assign mem_fault        = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage.
// Checks loads, stores, alignment faults, stall, reset, address aliasing and branch resolution.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [4:0]  EX_MEM_rd;
  logic [63:0] EX_MEM_mux_ALU;
  logic [63:0] EX_MEM_mux_ForwardB;
  logic        EX_MEM_ALUzero;
  logic [63:0] EX_MEM_adder2out;
  logic        EX_MEM_Branch;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic        EX_MEM_RegWrite;
  logic        EX_MEM_MemtoReg;
  logic [2:0]  EX_MEM_funct3;
  logic        PCSrc;
  logic [63:0] branch_target;
  logic [4:0]  MEM_WB_rd;
  logic [63:0] MEM_WB_ReadData;
  logic [63:0] MEM_WB_ALUresult;
  logic        MEM_WB_RegWrite;
  logic        MEM_WB_MemtoReg;
  logic        mem_fault;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.MEM_BYTES(512)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .EX_MEM_rd          (EX_MEM_rd),
    .EX_MEM_mux_ALU     (EX_MEM_mux_ALU),
    .EX_MEM_mux_ForwardB(EX_MEM_mux_ForwardB),
    .EX_MEM_ALUzero     (EX_MEM_ALUzero),
    .EX_MEM_adder2out   (EX_MEM_adder2out),
    .EX_MEM_Branch      (EX_MEM_Branch),
    .EX_MEM_MemRead     (EX_MEM_MemRead),
    .EX_MEM_MemWrite    (EX_MEM_MemWrite),
    .EX_MEM_RegWrite    (EX_MEM_RegWrite),
    .EX_MEM_MemtoReg    (EX_MEM_MemtoReg),
    .EX_MEM_funct3      (EX_MEM_funct3),
    .PCSrc              (PCSrc),
    .branch_target      (branch_target),
    .MEM_WB_rd          (MEM_WB_rd),
    .MEM_WB_ReadData    (MEM_WB_ReadData),
    .MEM_WB_ALUresult   (MEM_WB_ALUresult),
    .MEM_WB_RegWrite    (MEM_WB_RegWrite),
    .MEM_WB_MemtoReg    (MEM_WB_MemtoReg),
    .mem_fault          (mem_fault)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected $finish before 50000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Present one EX/MEM instruction, let one edge pass, then sample 1 unit later.
  task automatic acc(input logic mr, input logic mw, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] d,
                     input logic rw, input logic [4:0] rd);
    EX_MEM_MemRead      = mr;
    EX_MEM_MemWrite     = mw;
    EX_MEM_funct3       = f3;
    EX_MEM_mux_ALU      = a;
    EX_MEM_mux_ForwardB = d;
    EX_MEM_RegWrite     = rw;
    EX_MEM_MemtoReg     = mr;
    EX_MEM_rd           = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    EX_MEM_rd = 5'd0; EX_MEM_mux_ALU = 64'd0; EX_MEM_mux_ForwardB = 64'd0;
    EX_MEM_ALUzero = 1'b0; EX_MEM_adder2out = 64'd0; EX_MEM_Branch = 1'b0;
    EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0; EX_MEM_RegWrite = 1'b0;
    EX_MEM_MemtoReg = 1'b0; EX_MEM_funct3 = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", MEM_WB_ReadData, 64'd0);
    check("rst_alu",   MEM_WB_ALUresult, 64'd0);
    check("rst_rd",    {59'd0, MEM_WB_rd}, 64'd0);
    check("rst_ctrl",  {61'd0, MEM_WB_RegWrite, MEM_WB_MemtoReg, mem_fault}, 64'd0);
    reset = 1'b0;

    // sd then ld of the same doubleword
    acc(1'b0, 1'b1, 3'b011, 64'h10, 64'h8877665544332211, 1'b0, 5'd0);
    check("sd_fault", {63'd0, mem_fault}, 64'd0);
    acc(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd5);
    check("ld_data",  MEM_WB_ReadData, 64'h8877665544332211);
    check("ld_rw",    {63'd0, MEM_WB_RegWrite}, 64'd1);
    check("ld_m2r",   {63'd0, MEM_WB_MemtoReg}, 64'd1);
    check("ld_fault", {63'd0, mem_fault}, 64'd0);
    check("ld_rd",    {59'd0, MEM_WB_rd}, 64'd5);
    check("ld_alu",   MEM_WB_ALUresult, 64'h10);

    // sub-word loads
    acc(1'b1, 1'b0, 3'b000, 64'h17, 64'd0, 1'b1, 5'd1);
    check("lb_17",  MEM_WB_ReadData, 64'hFFFFFFFFFFFFFF88);
    acc(1'b1, 1'b0, 3'b100, 64'h17, 64'd0, 1'b1, 5'd1);
    check("lbu_17", MEM_WB_ReadData, 64'h88);
    acc(1'b1, 1'b0, 3'b001, 64'h16, 64'd0, 1'b1, 5'd1);
    check("lh_16",  MEM_WB_ReadData, 64'hFFFFFFFFFFFF8877);
    acc(1'b1, 1'b0, 3'b110, 64'h14, 64'd0, 1'b1, 5'd1);
    check("lwu_14", MEM_WB_ReadData, 64'h88776655);
    acc(1'b1, 1'b0, 3'b010, 64'h14, 64'd0, 1'b1, 5'd1);
    check("lw_14",  MEM_WB_ReadData, 64'hFFFFFFFF88776655);
    acc(1'b1, 1'b0, 3'b101, 64'h10, 64'd0, 1'b1, 5'd1);
    check("lhu_10", MEM_WB_ReadData, 64'h2211);

    // sb writes only its byte
    acc(1'b0, 1'b1, 3'b000, 64'h11, 64'h123456789ABCDEAB, 1'b0, 5'd0);
    acc(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd2);
    check("sb_merge", MEM_WB_ReadData, 64'h887766554433AB11);

    // non-memory ALU instruction passes through
    acc(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 1'b1, 5'd3);
    check("alu_rdata", MEM_WB_ReadData, 64'd0);
    check("alu_res",   MEM_WB_ALUresult, 64'h1234);
    check("alu_rw",    {63'd0, MEM_WB_RegWrite}, 64'd1);

    // misaligned lw faults for exactly one cycle
    acc(1'b1, 1'b0, 3'b010, 64'h12, 64'd0, 1'b1, 5'd4);
    check("lw12_fault", {63'd0, mem_fault}, 64'd1);
    check("lw12_rw",    {63'd0, MEM_WB_RegWrite}, 64'd0);
    check("lw12_data",  MEM_WB_ReadData, 64'd0);
    idle();
    check("fault_1cyc", {63'd0, mem_fault}, 64'd0);

    // misaligned sd leaves memory unchanged
    acc(1'b0, 1'b1, 3'b011, 64'h14, 64'hDEADBEEFDEADBEEF, 1'b0, 5'd0);
    check("sd14_fault", {63'd0, mem_fault}, 64'd1);
    acc(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd2);
    check("sd14_nowr", MEM_WB_ReadData, 64'h887766554433AB11);

    // reserved encodings and simultaneous read+write
    acc(1'b1, 1'b0, 3'b111, 64'h10, 64'd0, 1'b1, 5'd2);
    check("ld111_fault", {63'd0, mem_fault}, 64'd1);
    acc(1'b0, 1'b1, 3'b100, 64'h10, 64'hFF, 1'b0, 5'd0);
    check("st1xx_fault", {63'd0, mem_fault}, 64'd1);
    acc(1'b1, 1'b1, 3'b011, 64'h10, 64'd0, 1'b1, 5'd2);
    check("rdwr_fault", {63'd0, mem_fault}, 64'd1);
    acc(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd2);
    check("rsv_nowr", MEM_WB_ReadData, 64'h887766554433AB11);

    // address aliasing modulo 512
    acc(1'b1, 1'b0, 3'b011, 64'h210, 64'd0, 1'b1, 5'd6);
    check("alias_ld", MEM_WB_ReadData, 64'h887766554433AB11);
    acc(1'b0, 1'b1, 3'b001, 64'h21A, 64'h000000000000BEEF, 1'b0, 5'd0);
    acc(1'b1, 1'b0, 3'b011, 64'h18, 64'd0, 1'b1, 5'd6);
    check("alias_sh", MEM_WB_ReadData, 64'h00000000BEEF0000);

    // stall: no write, outputs hold, no fault
    acc(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd7);
    stall = 1'b1;
    acc(1'b0, 1'b1, 3'b010, 64'h20, 64'hCAFEBABE, 1'b1, 5'd9);
    check("stall_rd",   {59'd0, MEM_WB_rd}, 64'd7);
    check("stall_data", MEM_WB_ReadData, 64'h887766554433AB11);
    check("stall_alu",  MEM_WB_ALUresult, 64'h10);
    acc(1'b1, 1'b0, 3'b010, 64'h22, 64'd0, 1'b1, 5'd9);
    check("stall_nofault", {63'd0, mem_fault}, 64'd0);
    stall = 1'b0;
    acc(1'b1, 1'b0, 3'b110, 64'h20, 64'd0, 1'b1, 5'd8);
    check("stall_nowr", MEM_WB_ReadData, 64'd0);

    // branch resolution is combinational
    EX_MEM_Branch = 1'b1; EX_MEM_ALUzero = 1'b1; EX_MEM_adder2out = 64'h400;
    #1;
    check("br_taken",  {63'd0, PCSrc}, 64'd1);
    check("br_target", branch_target, 64'h400);
    EX_MEM_ALUzero = 1'b0;
    #1;
    check("br_nz", {63'd0, PCSrc}, 64'd0);
    EX_MEM_Branch = 1'b0; EX_MEM_ALUzero = 1'b1;
    #1;
    check("br_nobr", {63'd0, PCSrc}, 64'd0);

    // reset mid-sequence (with stall high) clears memory and outputs
    reset = 1'b1; stall = 1'b1; EX_MEM_Branch = 1'b1;
    acc(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd5);
    check("rst2_data", MEM_WB_ReadData, 64'd0);
    check("rst2_rd",   {59'd0, MEM_WB_rd}, 64'd0);
    check("rst2_ctrl", {61'd0, MEM_WB_RegWrite, MEM_WB_MemtoReg, mem_fault}, 64'd0);
    check("rst2_pcsrc", {63'd0, PCSrc}, 64'd1);
    reset = 1'b0; stall = 1'b0; EX_MEM_Branch = 1'b0;
    acc(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 1'b1, 5'd5);
    check("rst2_memclr", MEM_WB_ReadData, 64'd0);
    check("rst2_rw",     {63'd0, MEM_WB_RegWrite}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV64 pipeline, between the EX/MEM pipeline register and the write-back stage. It contains:
- the byte-addressed little-endian data memory, with size-aware loads and stores and misalignment detection;
- branch resolution (PCSrc / target);
- the MEM/WB pipeline register that feeds write-back.

Loads complete in one cycle. The loaded value appears on the MEM/WB outputs at the clock edge that ends the MEM cycle.

## Interface
Parameters
- MEM_BYTES, 512, data-memory size in bytes; power of two, ≥ 8
- AW, $clog2(MEM_BYTES), byte-address bits used for indexing

Ports
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold MEM/WB register, suppress memory write and fault
- EX_MEM_rd  in  5  destination register
- EX_MEM_mux_ALU  in  64  ALU result / effective byte address
- EX_MEM_mux_ForwardB  in  64  store data (forwarded rs2)
- EX_MEM_ALUzero  in  1  ALU zero flag
- EX_MEM_adder2out  in  64  branch target
- EX_MEM_Branch, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg  in  1 each  control
- EX_MEM_funct3  in  3  access size/sign
- PCSrc  out  1  take branch; combinational
- branch_target  out  64  = EX_MEM_adder2out; combinational
- MEM_WB_rd  out  5  registered rd
- MEM_WB_ReadData  out  64  registered load result
- MEM_WB_ALUresult  out  64  registered EX_MEM_mux_ALU
- MEM_WB_RegWrite, MEM_WB_MemtoReg  out  1 each  registered control
- mem_fault  out  1  registered one-cycle fault flag

## Operation
- **Branch resolution:** PCSrc = EX_MEM_Branch & EX_MEM_ALUzero. It does not depend on stall or reset.
- **Addressing:** addr = EX_MEM_mux_ALU[AW-1:0]. Upper bits are ignored, so addresses wrap modulo MEM_BYTES.
- **Load decode (funct3):**
  - 000 lb, 001 lh, 010 lw, 011 ld: sign-extended.
  - 100 lbu, 101 lhu, 110 lwu: zero-extended.
  - 111: reserved.
- **Store decode (funct3):** 000 sb, 001 sh, 010 sw, 011 sd. 1xx is reserved for stores.
- **Access width:** 1/2/4/8 bytes. An access is aligned iff addr mod width == 0.
- **Fault condition:** fault = (MemRead|MemWrite) & (misaligned | reserved funct3 | (MemRead & MemWrite)).
- **Store:** when MemWrite & !fault & !stall & !reset, write the low width bytes of ForwardB to bytes addr..addr+width-1 at the clock edge, little-endian. Other bytes are unchanged.
- **Load:** read is combinational from the memory array. The result is extended per funct3. Data is 0 when !MemRead or fault.
- **MEM/WB register update:** each edge with !stall & !reset:
  - rd, ALUresult, MemtoReg and ReadData are captured.
  - RegWrite is captured as EX_MEM_RegWrite & !fault.
  - mem_fault is captured as fault.
- **Stall:** all MEM/WB outputs hold their values. mem_fault holds 0. No memory write occurs.
- **Reset:**
  - All MEM/WB outputs and mem_fault go to 0.
  - All memory bytes are cleared to 0.
  - Reset has priority over stall.

## Timing
- PCSrc and branch_target: 0-cycle, combinational from EX/MEM inputs.
- Load: inputs in cycle N → MEM_WB_ReadData valid after the edge ending cycle N (latency 1).
- Store in cycle N followed by a load of the same address in cycle N+1: the load returns the new data. There is no bypass and none is needed.
- Store and load in the same cycle to different instructions is impossible, since there is one access per cycle.
- mem_fault is high for exactly one cycle per faulting access.
- Reset asserted mid-sequence: at the next edge memory is cleared, and outputs are 0 while reset is held.
- Outputs after reset: PCSrc follows inputs; all registered outputs = 0.

## Test plan
- Reset, then `sd` 0x8877665544332211 @0x10, then `ld` @0x10 → MEM_WB_ReadData = 0x8877665544332211, MEM_WB_RegWrite=1, mem_fault=0.
- Sub-word loads after the above store:
  - `lb` @0x17 → 0xFFFFFFFFFFFFFF88
  - `lbu` @0x17 → 0x88
  - `lh` @0x16 → 0xFFFFFFFFFFFF8877
  - `lwu` @0x14 → 0x88776655
- `sb` 0xAB @0x11 over the above, then `ld` @0x10 → 0x887766554433AB11. Other bytes are unchanged.
- Misalignment:
  - `lw` @0x12 → mem_fault=1 for one cycle, MEM_WB_RegWrite=0, ReadData=0.
  - `sd` @0x14 → memory unchanged, verified by a subsequent `ld` @0x10.
- Stall and reset:
  - stall=1 during `sw` @0x20 → no write, MEM/WB outputs hold.
  - Address 0x210 with MEM_BYTES=512 aliases to 0x10.
  - Reset asserted after the stores → `ld` @0x10 returns 0.
- Branch: Branch=1, ALUzero=1, adder2out=0x400 → PCSrc=1 and branch_target=0x400 in the same cycle. With ALUzero=0 → PCSrc=0.
